// File: rtl/inv_factorial.sv
// -----------------------------------------------------------------------------
// inv_factorial
//   Inverse factorial: for an unsigned target V, finds n, the largest integer
//   with n! <= V, and reports whether n! == V. The search multiplies up one
//   factorial per clock (1!, 2!, 3!, ...) until the next factorial would exceed
//   V. A conversion takes n clocks in CAL plus one clock in RESULT.
//   V = 0 skips CAL and reports n = 0, exact = 0.
//
// Ports
//   clk       : sole clock, rising edge
//   reset     : synchronous, active-high reset
//   start     : conversion request, sampled only in IDLE
//   fdata_in  : target value V, sampled on the edge that accepts start
//   busy      : high whenever the FSM is not in IDLE
//   done      : one-cycle pulse while in RESULT
//   fdata_out : n (registered, held until the next result)
//   exact     : n! == V (registered, held until the next result)
// -----------------------------------------------------------------------------
module inv_factorial #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] fdata_in,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  fdata_out,
  output logic              exact
);

  // Product width: a DATA_W accumulator times an OUT_W multiplier cannot
  // overflow this, so the "next factorial exceeds target" test is exact.
  localparam int ACC_W = DATA_W + OUT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAL    = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  target, target_nxt;
  logic [DATA_W-1:0]  acc, acc_nxt;
  logic [OUT_W-1:0]   k, k_nxt;
  logic [OUT_W-1:0]   out_nxt;
  logic               exact_nxt;
  logic [ACC_W-1:0]   prod;

  // acc * (k + 1), formed at full width without truncation.
  function automatic logic [ACC_W-1:0] mul_step(input logic [DATA_W-1:0] a,
                                                input logic [OUT_W-1:0]  kk);
    logic [ACC_W-1:0] a_w;
    logic [ACC_W-1:0] m_w;
    a_w = ACC_W'(a);
    m_w = ACC_W'(kk) + ACC_W'(1);
    return a_w * m_w;
  endfunction

  assign prod = mul_step(acc, k);

  // acc only ever holds a factorial that is <= target, so it fits in DATA_W
  // bits; the upper product bits only matter for the comparison.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    acc_nxt    = acc;
    k_nxt      = k;
    out_nxt    = fdata_out;
    exact_nxt  = exact;
    case (state)
      IDLE: begin
        if (start) begin
          if (fdata_in != '0) begin
            target_nxt = fdata_in;
            acc_nxt    = DATA_W'(1);
            k_nxt      = OUT_W'(1);
            state_nxt  = CAL;
          end else begin
            out_nxt   = '0;
            exact_nxt = 1'b0;
            state_nxt = RESULT;
          end
        end
      end
      CAL: begin
        if (prod <= ACC_W'(target)) begin
          acc_nxt = prod[DATA_W-1:0];
          k_nxt   = k + OUT_W'(1);
        end else begin
          out_nxt   = k;
          exact_nxt = (acc == target);
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      target    <= '0;
      acc       <= '0;
      k         <= '0;
      fdata_out <= '0;
      exact     <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      acc       <= acc_nxt;
      k         <= k_nxt;
      fdata_out <= out_nxt;
      exact     <= exact_nxt;
    end
  end

  // Decoded straight from the state register, so both are glitch-free.
  assign busy = (state != IDLE);
  assign done = (state == RESULT);

endmodule

// File: doc/inv_factorial.md
INV_FACTORIAL -- requirements
Module: inv_factorial

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to start a conversion; sampled only in IDLE.
REQ-005 SHALL have port fdata_in, input, 16 bits: unsigned target value V; sampled only on the edge that accepts start.
REQ-006 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-007 SHALL have port done, output, 1 bit: high only while in state RESULT; a one-cycle pulse.
REQ-008 SHALL have port fdata_out, output, 8 bits, registered: n, the largest integer with n! <= V.
REQ-009 SHALL have port exact, output, 1 bit, registered: high iff n! == V.

Function
REQ-010 SHALL implement three states: IDLE, CAL, RESULT.
REQ-011 In IDLE with start=1 and fdata_in != 0, SHALL latch target=fdata_in, set acc=1 and k=1, and go to CAL.
REQ-012 In IDLE with start=1 and fdata_in == 0, SHALL go directly to RESULT on that edge with fdata_out=0 and exact=0.
REQ-013 In IDLE with start=0, SHALL hold all state; fdata_in is ignored.
REQ-014 In CAL, SHALL form next = acc*(k+1), at least 20 bits wide with no truncation; a 24-bit width is used.
REQ-015 In CAL, if next <= target: acc <= next, k <= k+1, and stay in CAL.
REQ-016 In CAL, if next > target: go to RESULT, with fdata_out <= k and exact <= (acc == target).
REQ-017 SHALL keep k <= 8 for every 16-bit input, since 8! = 40320 and 9! = 362880 > 65535; k is an 8-bit register.
REQ-018 SHALL enter RESULT exactly n rising edges after the start-accepting edge, for V >= 1.
REQ-019 SHALL enter RESULT on the start-accepting edge itself, for V = 0.
REQ-020 In RESULT, SHALL go to IDLE unconditionally on the next edge; start asserted in RESULT is ignored.
REQ-021 SHALL ignore start while busy; no queuing; fdata_in changes during CAL have no effect.
REQ-022 SHALL update fdata_out and exact only on entry to RESULT, and hold them until the next entry to RESULT; they hold through IDLE and CAL.
REQ-023 SHALL accept back-to-back requests: start held high returns done every n+2 cycles (V >= 1).
REQ-024 SHALL produce fdata_out=1 and exact=1 for V=1; 0! is not reported.
REQ-025 SHALL keep the outputs busy and done free of glitches; they are decoded from registered state only.

Reset
REQ-026 With reset=1 at a rising edge, SHALL set state=IDLE, acc=0, k=0, target=0, fdata_out=0, exact=0; busy and done are then 0.
REQ-027 SHALL give reset priority over start and over any in-progress CAL; reset mid-operation aborts with no done pulse.
REQ-028 SHALL accept start on the first edge after reset deasserts.

Verification
REQ-029 Start with fdata_in=120 -> RESULT 5 edges later; done for 1 cycle; fdata_out=5, exact=1; busy high for 6 cycles.
REQ-030 Start with fdata_in=719 -> fdata_out=5, exact=0 after 5 edges; also fdata_in=720 -> fdata_out=6, exact=1 after 6 edges.
REQ-031 Cover the boundaries: fdata_in=0 gives fdata_out=0, exact=0, done 1 cycle after start.
REQ-032 Cover the boundaries: fdata_in=1 gives fdata_out=1, exact=1, done after 1 edge.
REQ-033 Cover the boundaries: fdata_in=40320 gives fdata_out=8, exact=1; fdata_in=65535 gives fdata_out=8, exact=0; 8 edges each.
REQ-034 Start with fdata_in=5040; assert reset at the 3rd CAL cycle -> all outputs 0 next cycle, no done pulse; then start with fdata_in=2 -> fdata_out=2, exact=1.
REQ-035 Pulse start during CAL and during RESULT, and change fdata_in mid-CAL -> no effect on the result; sweep all 65536 inputs against a software model of n and exact.
